// File: rtl/ir_tx_pkg.sv
// ir_tx_pkg: state encoding and 125 MHz default timing for the IR frame transmitter
package ir_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SEG0, S_LINK, S_SEG1, S_TRAIL, S_GAP} ir_state_e;
  localparam int unsigned DEF_CARRIER_DIV  = 3289;
  localparam int unsigned DEF_T_LEAD_MARK  = 1125000;
  localparam int unsigned DEF_T_LEAD_SPACE = 562500;
  localparam int unsigned DEF_T_BIT_MARK   = 93750;
  localparam int unsigned DEF_T_SPACE0     = 56250;
  localparam int unsigned DEF_T_SPACE1     = 187500;
  localparam int unsigned DEF_T_LINK_SPACE = 2500000;
  localparam int unsigned DEF_T_GAP        = 5000000;
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: 50% duty carrier whose phase restarts on the first cycle of each mark
module ir_carrier_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic carrier
);
  localparam int unsigned W = $clog2(DIV + 1);
  localparam logic [W-1:0] HALF = W'(DIV / 2);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt;
  // restart overrides combinationally so the mark's first cycle already sees phase 0
  assign w_cnt = restart ? '0 : r_cnt;
  assign carrier = w_cnt < HALF;
  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else if (en) r_cnt <= w_cnt == LAST ? '0 : w_cnt + 1'b1;
  end
endmodule

// File: rtl/ir_frame_tx.sv
// ir_frame_tx: sends lead, SEG0, optional link+SEG1 and trail as a carrier-modulated IR frame with repeats
module ir_frame_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned CARRIER_DIV  = DEF_CARRIER_DIV,
  parameter int unsigned T_LEAD_MARK  = DEF_T_LEAD_MARK,
  parameter int unsigned T_LEAD_SPACE = DEF_T_LEAD_SPACE,
  parameter int unsigned T_BIT_MARK   = DEF_T_BIT_MARK,
  parameter int unsigned T_SPACE0     = DEF_T_SPACE0,
  parameter int unsigned T_SPACE1     = DEF_T_SPACE1,
  parameter int unsigned T_LINK_SPACE = DEF_T_LINK_SPACE,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter int unsigned SEG0_BITS    = 35,
  parameter int unsigned SEG1_BITS    = 32,
  parameter bit          OUT_INV      = 1'b0,
  localparam int unsigned S1W = SEG1_BITS > 0 ? SEG1_BITS : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SEG0_BITS-1:0] seg0_data,
  input  logic [S1W-1:0]       seg1_data,
  input  logic [3:0]           repeat_cnt,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 ir_env,
  output logic                 ir_out
);
  localparam int unsigned T_MAX = max2(max2(max2(T_LEAD_MARK, T_LEAD_SPACE), max2(T_BIT_MARK, T_SPACE0)),
                                       max2(max2(T_SPACE1, T_LINK_SPACE), T_GAP));
  localparam int unsigned CW = $clog2(T_MAX) + 1;
  localparam logic [CW-1:0] L_LM = CW'(T_LEAD_MARK);
  localparam logic [CW-1:0] L_LS = CW'(T_LEAD_SPACE);
  localparam logic [CW-1:0] L_BM = CW'(T_BIT_MARK);
  localparam logic [CW-1:0] L_S0 = CW'(T_SPACE0);
  localparam logic [CW-1:0] L_S1 = CW'(T_SPACE1);
  localparam logic [CW-1:0] L_LK = CW'(T_LINK_SPACE);
  localparam logic [CW-1:0] L_GP = CW'(T_GAP);
  localparam logic [5:0] B0 = 6'(SEG0_BITS - 1);
  localparam logic [5:0] B1 = 6'(S1W - 1);
  ir_state_e            r_state, w_nstate;
  logic                 r_mark, w_nmark, r_first;
  logic [CW-1:0]        r_cnt, w_nlen;
  logic [5:0]           r_bit, w_nbit;
  logic [3:0]           r_rep;
  logic [SEG0_BITS-1:0] r_seg0, w_sh0;
  logic [S1W-1:0]       r_seg1, w_sh1;
  logic                 r_ready, r_busy, r_done, r_aborted, r_env;
  logic                 w_carrier;
  // next phase and its length, taken when the current phase counter expires
  always_comb begin
    w_sh0 = r_seg0 >> r_bit;
    w_sh1 = r_seg1 >> r_bit;
    w_nstate = r_state;
    w_nmark = !r_mark;
    w_nbit = r_bit;
    w_nlen = L_BM;
    case (r_state)
      S_LEAD:
        if (r_mark) w_nlen = L_LS;
        else begin
          w_nstate = S_SEG0;
          w_nbit = B0;
        end
      S_SEG0:
        if (r_mark) w_nlen = w_sh0[0] ? L_S1 : L_S0;
        else if (r_bit != 6'd0) w_nbit = r_bit - 6'd1;
        else w_nstate = SEG1_BITS > 0 ? S_LINK : S_TRAIL;
      S_LINK:
        if (r_mark) w_nlen = L_LK;
        else begin
          w_nstate = S_SEG1;
          w_nbit = B1;
        end
      S_SEG1:
        if (r_mark) w_nlen = w_sh1[0] ? L_S1 : L_S0;
        else if (r_bit != 6'd0) w_nbit = r_bit - 6'd1;
        else w_nstate = S_TRAIL;
      S_TRAIL: begin
        w_nstate = r_rep != 4'd0 ? S_GAP : S_IDLE;
        w_nlen = L_GP;
      end
      S_GAP: begin
        w_nstate = S_LEAD;
        w_nlen = L_LM;
      end
      default: begin
        w_nstate = S_LEAD;
        w_nmark = 1'b1;
        w_nlen = L_LM;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mark <= 1'b0;
      r_first <= 1'b0;
      r_cnt <= '0;
      r_bit <= '0;
      r_rep <= '0;
      r_seg0 <= '0;
      r_seg1 <= '0;
      r_ready <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_aborted <= 1'b0;
      r_env <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_aborted <= 1'b0;
      r_first <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_seg0 <= seg0_data;
          r_seg1 <= seg1_data;
          r_rep <= repeat_cnt;
          r_state <= w_nstate;
          r_mark <= 1'b1;
          r_cnt <= w_nlen - 1'b1;
          r_env <= 1'b1;
          r_first <= 1'b1;
          r_ready <= 1'b0;
          r_busy <= 1'b1;
        end
      end else if (abort) begin
        r_state <= S_IDLE;
        r_mark <= 1'b0;
        r_cnt <= '0;
        r_env <= 1'b0;
        r_ready <= 1'b1;
        r_busy <= 1'b0;
        r_aborted <= 1'b1;
      end else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      else begin
        r_state <= w_nstate;
        r_mark <= w_nmark;
        r_bit <= w_nbit;
        r_cnt <= w_nlen - 1'b1;
        r_env <= w_nmark;
        r_first <= w_nmark;
        if (r_state == S_TRAIL && r_rep != 4'd0) r_rep <= r_rep - 4'd1;
        if (w_nstate == S_IDLE) begin
          r_done <= 1'b1;
          r_ready <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end
  ir_carrier_gen #(.DIV(CARRIER_DIV)) u_carrier (
    .clk(clk),
    .rst(rst),
    .restart(r_first),
    .en(r_env),
    .carrier(w_carrier)
  );
  assign ready = r_ready;
  assign busy = r_busy;
  assign done = r_done;
  assign aborted = r_aborted;
  assign ir_env = r_env;
  assign ir_out = (r_env & w_carrier) ^ OUT_INV;
endmodule

// File: tb/tb_ir_frame_tx.sv
// tb_ir_frame_tx: directed frame, carrier, repeat, abort and reset checks against hand-derived timelines
module tb_ir_frame_tx;
  logic clk = 1'b0;
  logic rst, start, s0_start, abort;
  logic [2:0] seg0;
  logic [1:0] seg1;
  logic [3:0] rep;
  logic a_ready, a_busy, a_done, a_aborted, a_env, a_out;
  logic i_ready, i_busy, i_done, i_aborted, i_env, i_out;
  logic z_ready, z_busy, z_done, z_aborted, z_env, z_out;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ir_frame_tx #(.CARRIER_DIV(4), .T_LEAD_MARK(16), .T_LEAD_SPACE(8), .T_BIT_MARK(4), .T_SPACE0(4),
    .T_SPACE1(12), .T_LINK_SPACE(20), .T_GAP(40), .SEG0_BITS(3), .SEG1_BITS(2), .OUT_INV(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start), .seg0_data(seg0), .seg1_data(seg1), .repeat_cnt(rep),
    .abort(abort), .ready(a_ready), .busy(a_busy), .done(a_done), .aborted(a_aborted),
    .ir_env(a_env), .ir_out(a_out));
  ir_frame_tx #(.CARRIER_DIV(4), .T_LEAD_MARK(16), .T_LEAD_SPACE(8), .T_BIT_MARK(4), .T_SPACE0(4),
    .T_SPACE1(12), .T_LINK_SPACE(20), .T_GAP(40), .SEG0_BITS(3), .SEG1_BITS(2), .OUT_INV(1'b1)) u_inv (
    .clk(clk), .rst(rst), .start(start), .seg0_data(seg0), .seg1_data(seg1), .repeat_cnt(rep),
    .abort(abort), .ready(i_ready), .busy(i_busy), .done(i_done), .aborted(i_aborted),
    .ir_env(i_env), .ir_out(i_out));
  ir_frame_tx #(.CARRIER_DIV(4), .T_LEAD_MARK(16), .T_LEAD_SPACE(8), .T_BIT_MARK(4), .T_SPACE0(4),
    .T_SPACE1(12), .T_LINK_SPACE(20), .T_GAP(40), .SEG0_BITS(3), .SEG1_BITS(0), .OUT_INV(1'b0)) u_s0 (
    .clk(clk), .rst(rst), .start(s0_start), .seg0_data(3'b000), .seg1_data(1'b0), .repeat_cnt(4'd0),
    .abort(abort), .ready(z_ready), .busy(z_busy), .done(z_done), .aborted(z_aborted),
    .ir_env(z_env), .ir_out(z_out));
  task automatic check(input string tag, input int c, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got {rdy,bsy,done,abt,env,out}=%b expected %b", tag, c, got, exp);
    end
  endtask
  function automatic int ph_a(input int c);
    int s[8] = '{1, 25, 41, 49, 65, 89, 97, 113};
    int l[8] = '{16, 4, 4, 4, 4, 4, 4, 4};
    for (int i = 0; i < 8; i++) if (c >= s[i] && c < s[i] + l[i]) return c - s[i];
    return -1;
  endfunction
  function automatic int ph_s0(input int c);
    int s[5] = '{1, 25, 33, 41, 49};
    int l[5] = '{16, 4, 4, 4, 4};
    for (int i = 0; i < 5; i++) if (c >= s[i] && c < s[i] + l[i]) return c - s[i];
    return -1;
  endfunction
  function automatic logic [5:0] vec(input logic bsy, input logic dn, input logic ab, input int ph, input logic inv);
    logic env = ph >= 0;
    logic o = env && (ph % 4 < 2);
    return {!bsy, bsy, dn, ab, env, o ^ inv};
  endfunction
  task automatic run(input int t, input int n);
    for (int c = 0; c <= n; c++) begin
      int ph;
      logic bsy, dn, ab;
      @(negedge clk);
      ab = 1'b0;
      case (t)
        1: begin ph = ph_a(c); bsy = c >= 1 && c <= 116; dn = c == 117; end
        2: begin ph = ph_a(c) >= 0 ? ph_a(c) : ph_a(c - 156); bsy = c >= 1 && c <= 272; dn = c == 273; end
        3: begin
          ph = c <= 30 ? ph_a(c) : ph_a(c - 40);
          bsy = (c >= 1 && c <= 30) || (c >= 41 && c <= 156);
          dn = c == 157;
          ab = c == 31;
        end
        default: begin ph = c <= 60 ? ph_a(c) : -1; bsy = c >= 1 && c <= 60; dn = 1'b0; end
      endcase
      check("frame", c, {a_ready, a_busy, a_done, a_aborted, a_env, a_out}, vec(bsy, dn, ab, ph, 1'b0));
      check("inv", c, {i_ready, i_busy, i_done, i_aborted, i_env, i_out}, vec(bsy, dn, ab, ph, 1'b1));
      check("seg1_none", c, {z_ready, z_busy, z_done, z_aborted, z_env, z_out},
            t == 1 ? vec(c >= 1 && c <= 52, c == 53, 1'b0, ph_s0(c), 1'b0) : vec(1'b0, 1'b0, 1'b0, -1, 1'b0));
      start = c == 0 || (t == 1 && c == 50) || (t == 3 && c == 40) || (t == 4 && (c == 61 || c == 62));
      s0_start = t == 1 && c == 0;
      abort = t == 3 && (c == 30 || c == 40);
      rst = !(t == 4 && c >= 60 && c <= 62);
      if (t == 2 && c == 50) seg0 = 3'b010;
    end
  endtask
  initial begin
    rst = 1'b0;
    start = 1'b0;
    s0_start = 1'b0;
    abort = 1'b0;
    seg0 = 3'b101;
    seg1 = 2'b01;
    rep = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a", 0, {a_ready, a_busy, a_done, a_aborted, a_env, a_out}, 6'b100000);
    check("rst_inv", 0, {i_ready, i_busy, i_done, i_aborted, i_env, i_out}, 6'b100001);
    check("rst_s0", 0, {z_ready, z_busy, z_done, z_aborted, z_env, z_out}, 6'b100000);
    rst = 1'b1;
    run(1, 125);
    rep = 4'd1;
    run(2, 280);
    rep = 4'd0;
    seg0 = 3'b101;
    run(3, 160);
    run(4, 70);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_frame_tx.md
Name: ir_frame_tx

Overview:
- Parametrised successor to the fixed-format IR air-conditioner transmitter.
- Sends one IR frame of up to two data segments, modulated on a carrier: lead mark/space, SEG0 bits, link mark/space, SEG1 bits, trail mark.
- Supports configurable frame repeats, a start/ready handshake, abort and done/aborted status.
- Sits between the command-formatting logic and the IR LED pin.

Parameters:
- CARRIER_DIV, 3289: clk cycles per carrier period (125 MHz / 38 kHz).
- T_LEAD_MARK, 1125000: lead mark cycles (9 ms).
- T_LEAD_SPACE, 562500: lead space cycles (4.5 ms).
- T_BIT_MARK, 93750: mark cycles for every bit, link and trail (750 us).
- T_SPACE0, 56250: space cycles for bit 0 (450 us).
- T_SPACE1, 187500: space cycles for bit 1 (1500 us).
- T_LINK_SPACE, 2500000: link space cycles (20 ms).
- T_GAP, 5000000: inter-frame space cycles before a repeat (40 ms).
- SEG0_BITS, 35: SEG0 length, 1..63.
- SEG1_BITS, 32: SEG1 length, 0..63; 0 omits link and SEG1.
- OUT_INV, 0: 1 inverts ir_out, so the idle level becomes 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- start  in  1  request; accepted only when start && ready.
- seg0_data  in  SEG0_BITS  SEG0 payload, sent MSB first.
- seg1_data  in  SEG1_BITS (min 1)  SEG1 payload, sent MSB first.
- repeat_cnt  in  4  extra frame transmissions after the first.
- abort  in  1  terminates the transmission in progress.
- ready  out  1  high in IDLE.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse after normal completion.
- aborted  out  1  one-cycle pulse after an abort.
- ir_env  out  1  envelope; 1 during a mark.
- ir_out  out  1  (ir_env & carrier) ^ OUT_INV.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE. ready=1; busy=done=aborted=ir_env=0; ir_out=OUT_INV. Counters and shadow registers are cleared. Reset mid-frame stops the output at that edge.
- Accept: in IDLE with start=1, the block latches seg0_data, seg1_data and repeat_cnt. At that edge ready=0 and busy=1. ir_env goes 1 in the first following cycle (latency 1). start while busy is ignored; latched data is never changed mid-frame.
- States: IDLE, LEAD, SEG0, LINK, SEG1, TRAIL, GAP. Every mark and every space lasts exactly its T_* cycles. One down-counter is loaded with T-1 and the phase advances when it reaches 0.
- IDLE -> LEAD on accept.
- LEAD: T_LEAD_MARK mark, then T_LEAD_SPACE space, then SEG0.
- SEG0 and SEG1: bit index runs N-1 down to 0. Each bit is T_BIT_MARK mark followed by T_SPACE1 (bit=1) or T_SPACE0 (bit=0) space.
- After SEG0: go to LINK (T_BIT_MARK mark, then T_LINK_SPACE space, then SEG1) if SEG1_BITS>0; otherwise go straight to TRAIL.
- TRAIL: T_BIT_MARK mark.
- After TRAIL: if the remaining-repeat counter is nonzero, decrement it and go to GAP (T_GAP space), then LEAD. If it is zero, go to IDLE.
- On the IDLE entry edge after normal completion: done=1 for one cycle and ready=1 in the same cycle.
- Carrier: counter 0..CARRIER_DIV-1. It restarts at 0 on the first cycle of every mark. carrier=1 while count < CARRIER_DIV/2. Outside marks, ir_out stays at its idle level.
- Abort: abort=1 while busy goes to IDLE at the next edge. ir_env drops to 0 at that edge, aborted pulses for one cycle, done stays 0. Abort in IDLE is ignored.
- Simultaneous start and abort in IDLE: the start is accepted and the abort is ignored.
- Counter width: clog2 of the largest T_* parameter, plus 1. Bit index is 6 bits; repeat counter is 4 bits, with no wrap because it stops at 0.

Decomposition:
- Package ir_tx_pkg holds the state enum and the default timing constants for 125 MHz.
- One sub-module, ir_carrier_gen: parameter DIV; inputs clk, rst, restart, en; output carrier.

Test Plan (all scenarios use CARRIER_DIV=4, T_LEAD_MARK=16, T_LEAD_SPACE=8, T_BIT_MARK=4, T_SPACE0=4, T_SPACE1=12, T_LINK_SPACE=20, T_GAP=40, SEG0_BITS=3, SEG1_BITS=2):
- Single frame: seg0=3'b101, seg1=2'b01, repeat=0, start at cycle 0.
  - busy cycles 1..116.
  - ir_env=1 at cycles 1-16, 25-28, 41-44, 49-52, 65-68, 89-92, 97-100, 113-116.
  - done=1 and ready=1 at cycle 117 only.
- Carrier: during cycles 1-16, ir_out = 1,1,0,0 repeating, then 0 in cycles 17-24. The same run with OUT_INV=1 gives the inverted pattern and ir_out=1 in idle.
- Repeat: repeat_cnt=1 with the same data.
  - Second LEAD mark starts at cycle 157.
  - done at cycle 273 exactly once.
  - Changing seg0_data at cycle 50 does not alter either frame.
- SEG1_BITS=0, seg0=3'b000: TRAIL mark at cycles 49-52; done at cycle 53.
- Abort at cycle 30: ir_env=0 from cycle 31; aborted=1 at cycle 31; done never asserts. A new start at cycle 40 produces a full frame.
- Reset: rst=0 at cycle 60 mid-frame gives all outputs at reset values from the next edge. start together with rst=0 is ignored. Start ignored while busy: busy length is unchanged.
